// File: rtl/fetch_sequencer_pkg.sv
// Shared types and constants for the fetch sequencer: FSM encoding, PC step
// and the load-use hazard test used by the control logic.
package fetch_sequencer_pkg;

  localparam int REG_IDX_W = 5;
  localparam int PC_STEP   = 4;

  typedef enum logic {
    RUN        = 1'b0,
    REDIR_PEND = 1'b1
  } seq_state_t;

  // Register x0 is hardwired to zero, so a load targeting it never creates a hazard.
  function automatic logic load_use_hazard(
    input logic                 mem_read,
    input logic [REG_IDX_W-1:0] ex_rd,
    input logic [REG_IDX_W-1:0] rs1,
    input logic [REG_IDX_W-1:0] rs2,
    input logic                 uses_rs1,
    input logic                 uses_rs2
  );
    return mem_read && (ex_rd != '0) &&
           ((uses_rs1 && (rs1 == ex_rd)) || (uses_rs2 && (rs2 == ex_rd)));
  endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// Bundle of pipeline-status inputs and PC/stage control outputs of the fetch sequencer.
// The slave modport is the sequencer itself; master is the pipeline side.
interface fetch_sequencer_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
);
  import fetch_sequencer_pkg::*;

  logic                 ex_branch_taken;
  logic [XLEN-1:0]      ex_branch_target;
  logic                 ex_mem_read;
  logic [REG_IDX_W-1:0] ex_rd;
  logic [REG_IDX_W-1:0] id_rs1;
  logic [REG_IDX_W-1:0] id_rs2;
  logic                 id_uses_rs1;
  logic                 id_uses_rs2;
  logic                 imem_ready;

  logic                 imem_req;
  logic                 pc_hold;
  logic                 pc_src;
  logic [XLEN-1:0]      pc_target;
  logic                 if_id_hold;
  logic                 if_id_flush;
  logic                 id_ex_flush;
  logic [CNT_W-1:0]     stall_cycles;
  logic [CNT_W-1:0]     redirect_count;

  modport slave (
    input  ex_branch_taken, ex_branch_target, ex_mem_read, ex_rd,
           id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, imem_ready,
    output imem_req, pc_hold, pc_src, pc_target, if_id_hold,
           if_id_flush, id_ex_flush, stall_cycles, redirect_count
  );

  modport master (
    output ex_branch_taken, ex_branch_target, ex_mem_read, ex_rd,
           id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, imem_ready,
    input  imem_req, pc_hold, pc_src, pc_target, if_id_hold,
           if_id_flush, id_ex_flush, stall_cycles, redirect_count
  );

endinterface

// File: rtl/fetch_sequencer_sat_counter.sv
// Performance counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_count
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_inc && (r_count != '1)) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/fetch_sequencer.sv
// Front-end control: arbitrates branch redirects, load-use stalls and imem wait
// states into PC hold/select and IF/ID, ID/EX hold/flush, with zero added latency.
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter int CNT_W = 16,
  parameter int XLEN  = 32
) (
  input  logic                clk,
  input  logic                reset,
  fetch_sequencer_if.slave    io_fs
);

  seq_state_t      r_state;
  seq_state_t      w_next_state;
  logic [XLEN-1:0] r_redirect_addr;
  logic [XLEN-1:0] w_redirect_addr_next;
  logic            w_load_use;
  logic            w_redirect_inc;
  logic            w_stall_inc;

  assign w_load_use = load_use_hazard(io_fs.ex_mem_read, io_fs.ex_rd,
                                      io_fs.id_rs1, io_fs.id_rs2,
                                      io_fs.id_uses_rs1, io_fs.id_uses_rs2);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state         <= RUN;
      r_redirect_addr <= '0;
    end else begin
      r_state         <= w_next_state;
      r_redirect_addr <= w_redirect_addr_next;
    end
  end

  // A redirect that cannot fetch yet is parked in REDIR_PEND; its target is replayed once imem is ready.
  always_comb begin
    io_fs.imem_req       = 1'b1;
    io_fs.pc_hold        = 1'b0;
    io_fs.pc_src         = 1'b0;
    io_fs.pc_target      = io_fs.ex_branch_target;
    io_fs.if_id_hold     = 1'b0;
    io_fs.if_id_flush    = 1'b0;
    io_fs.id_ex_flush    = 1'b0;
    w_next_state         = r_state;
    w_redirect_addr_next = r_redirect_addr;
    w_redirect_inc       = 1'b0;

    if (reset) begin
      io_fs.imem_req       = 1'b0;
      io_fs.pc_target      = '0;
      io_fs.if_id_flush    = 1'b1;
      io_fs.id_ex_flush    = 1'b1;
      w_next_state         = RUN;
      w_redirect_addr_next = '0;
    end else begin
      case (r_state)
        RUN: begin
          if (io_fs.ex_branch_taken) begin
            w_redirect_inc    = 1'b1;
            io_fs.if_id_flush = 1'b1;
            io_fs.id_ex_flush = 1'b1;
            if (io_fs.imem_ready) begin
              io_fs.pc_src = 1'b1;
            end else begin
              io_fs.pc_hold        = 1'b1;
              w_redirect_addr_next = io_fs.ex_branch_target;
              w_next_state         = REDIR_PEND;
            end
          end else if (w_load_use) begin
            io_fs.pc_hold     = 1'b1;
            io_fs.if_id_hold  = 1'b1;
            io_fs.id_ex_flush = 1'b1;
          end else if (!io_fs.imem_ready) begin
            io_fs.pc_hold     = 1'b1;
            io_fs.if_id_flush = 1'b1;
          end
        end

        REDIR_PEND: begin
          io_fs.pc_target   = r_redirect_addr;
          io_fs.if_id_flush = 1'b1;
          io_fs.id_ex_flush = 1'b1;
          if (io_fs.ex_branch_taken) begin
            w_redirect_inc       = 1'b1;
            w_redirect_addr_next = io_fs.ex_branch_target;
          end
          if (io_fs.imem_ready) begin
            io_fs.pc_src = 1'b1;
            w_next_state = RUN;
          end else begin
            io_fs.pc_hold = 1'b1;
          end
        end

        default: w_next_state = RUN;
      endcase
    end
  end

  assign w_stall_inc = io_fs.pc_hold && !reset;

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk     (clk),
    .reset   (reset),
    .i_inc   (w_stall_inc),
    .o_count (io_fs.stall_cycles)
  );

  sat_counter #(.CNT_W(CNT_W)) u_redirect_cnt (
    .clk     (clk),
    .reset   (reset),
    .i_inc   (w_redirect_inc),
    .o_count (io_fs.redirect_count)
  );

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: expected control outputs are queued with each
// stimulus step and popped/compared mid-cycle; counters are checked against constants.
module tb_fetch_sequencer;

  localparam int XLEN  = 32;
  localparam int CNT_W = 16;

  typedef struct {
    string       tag;
    logic        imem_req;
    logic        pc_hold;
    logic        pc_src;
    logic        if_id_hold;
    logic        if_id_flush;
    logic        id_ex_flush;
    logic        check_target;
    logic [31:0] pc_target;
  } exp_t;

  logic clk;
  logic reset;
  int   testsRun;
  int   testsFailed;
  exp_t sbq[$];

  fetch_sequencer_if #(.XLEN(XLEN), .CNT_W(CNT_W)) fsIf ();

  fetch_sequencer #(.CNT_W(CNT_W), .XLEN(XLEN)) dut (
    .clk   (clk),
    .reset (reset),
    .io_fs (fsIf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testsRun++;
    assert (obs === exp) else begin
      testsFailed++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drives one cycle of inputs at the negedge and queues what the outputs must be.
  task automatic applyStimulus(
    input string       tag,
    input logic        rst,
    input logic        br,
    input logic [31:0] tgt,
    input logic        ready,
    input logic        memRd,
    input logic [4:0]  rd,
    input logic [4:0]  rs1,
    input logic [4:0]  rs2,
    input logic        use1,
    input logic        use2,
    input logic        eHold,
    input logic        eSrc,
    input logic        eIfHold,
    input logic        eIfFlush,
    input logic        eIdFlush,
    input logic        eChkTgt,
    input logic [31:0] eTgt
  );
    exp_t e;
    @(negedge clk);
    reset                  = rst;
    fsIf.ex_branch_taken   = br;
    fsIf.ex_branch_target  = tgt;
    fsIf.imem_ready        = ready;
    fsIf.ex_mem_read       = memRd;
    fsIf.ex_rd             = rd;
    fsIf.id_rs1            = rs1;
    fsIf.id_rs2            = rs2;
    fsIf.id_uses_rs1       = use1;
    fsIf.id_uses_rs2       = use2;
    e.tag          = tag;
    e.imem_req     = !rst;
    e.pc_hold      = eHold;
    e.pc_src       = eSrc;
    e.if_id_hold   = eIfHold;
    e.if_id_flush  = eIfFlush;
    e.id_ex_flush  = eIdFlush;
    e.check_target = eChkTgt;
    e.pc_target    = eTgt;
    sbq.push_back(e);
  endtask

  task automatic checkOutput();
    exp_t e;
    #1;
    if (sbq.size() == 0) begin
      testsRun++;
      testsFailed++;
      $error("[TB] FAIL scoreboard_empty observed=0 expected=1");
      return;
    end
    e = sbq.pop_front();
    cmp({e.tag, ".imem_req"},    32'(fsIf.imem_req),    32'(e.imem_req));
    cmp({e.tag, ".pc_hold"},     32'(fsIf.pc_hold),     32'(e.pc_hold));
    cmp({e.tag, ".pc_src"},      32'(fsIf.pc_src),      32'(e.pc_src));
    cmp({e.tag, ".if_id_hold"},  32'(fsIf.if_id_hold),  32'(e.if_id_hold));
    cmp({e.tag, ".if_id_flush"}, 32'(fsIf.if_id_flush), 32'(e.if_id_flush));
    cmp({e.tag, ".id_ex_flush"}, 32'(fsIf.id_ex_flush), 32'(e.id_ex_flush));
    if (e.check_target) cmp({e.tag, ".pc_target"}, fsIf.pc_target, e.pc_target);
  endtask

  task automatic checkCounters(input string tag, input int eStall, input int eRedir);
    cmp({tag, ".stall_cycles"},   32'(fsIf.stall_cycles),   eStall);
    cmp({tag, ".redirect_count"}, 32'(fsIf.redirect_count), eRedir);
  endtask

  // Idle cycle: fetch ready, no branch, no hazard; every control output is low.
  task automatic idleStep(input string tag);
    applyStimulus(tag, 0, 0, 32'h0, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0,
                  0, 0, 0, 0, 0, 0, 32'h0);
    checkOutput();
  endtask

  initial begin
    testsRun    = 0;
    testsFailed = 0;
    reset       = 1'b1;
    fsIf.ex_branch_taken  = 1'b0;
    fsIf.ex_branch_target = '0;
    fsIf.imem_ready       = 1'b0;
    fsIf.ex_mem_read      = 1'b0;
    fsIf.ex_rd            = '0;
    fsIf.id_rs1           = '0;
    fsIf.id_rs2           = '0;
    fsIf.id_uses_rs1      = 1'b0;
    fsIf.id_uses_rs2      = 1'b0;

    for (int i = 0; i < 3; i++) begin
      applyStimulus("reset", 1, 1, 32'hDEAD_BEEF, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0,
                    0, 0, 0, 1, 1, 1, 32'h0);
      checkOutput();
    end
    idleStep("release");
    checkCounters("after_reset", 0, 0);

    applyStimulus("br_ready", 0, 1, 32'h0000_0100, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0,
                  0, 1, 0, 1, 1, 1, 32'h0000_0100);
    checkOutput();
    idleStep("br_ready_stays_run");
    checkCounters("br_ready", 0, 1);

    applyStimulus("br_wait0", 0, 1, 32'h0000_0200, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0,
                  1, 0, 0, 1, 1, 0, 32'h0);
    checkOutput();
    for (int i = 0; i < 2; i++) begin
      applyStimulus("redir_pend_wait", 0, 0, 32'h0000_0BAD, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0,
                    1, 0, 0, 1, 1, 0, 32'h0);
      checkOutput();
    end
    applyStimulus("redir_issue", 0, 0, 32'h0000_0BAD, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0,
                  0, 1, 0, 1, 1, 1, 32'h0000_0200);
    checkOutput();
    idleStep("redir_back_to_run");
    checkCounters("br_wait", 3, 2);

    applyStimulus("load_use_rs2", 0, 0, 32'h0, 1, 1, 5'd5, 5'd1, 5'd5, 0, 1,
                  1, 0, 1, 0, 1, 0, 32'h0);
    checkOutput();
    idleStep("load_use_one_cycle");
    applyStimulus("load_use_imem_wait", 0, 0, 32'h0, 0, 1, 5'd5, 5'd1, 5'd5, 0, 1,
                  1, 0, 1, 0, 1, 0, 32'h0);
    checkOutput();
    applyStimulus("load_use_rs1", 0, 0, 32'h0, 1, 1, 5'd7, 5'd7, 5'd2, 1, 0,
                  1, 0, 1, 0, 1, 0, 32'h0);
    checkOutput();
    applyStimulus("load_x0_no_stall", 0, 0, 32'h0, 1, 1, 5'd0, 5'd0, 5'd0, 1, 1,
                  0, 0, 0, 0, 0, 0, 32'h0);
    checkOutput();
    applyStimulus("match_unused_no_stall", 0, 0, 32'h0, 1, 1, 5'd9, 5'd9, 5'd9, 0, 0,
                  0, 0, 0, 0, 0, 0, 32'h0);
    checkOutput();
    applyStimulus("branch_beats_load_use", 0, 1, 32'h0000_0300, 1, 1, 5'd5, 5'd5, 5'd5, 1, 1,
                  0, 1, 0, 1, 1, 1, 32'h0000_0300);
    checkOutput();
    applyStimulus("imem_wait_alone", 0, 0, 32'h0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0,
                  1, 0, 0, 1, 0, 0, 32'h0);
    checkOutput();
    idleStep("after_imem_wait");
    checkCounters("hazards", 7, 3);

    applyStimulus("br_into_pend", 0, 1, 32'h0000_0400, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0,
                  1, 0, 0, 1, 1, 0, 32'h0);
    checkOutput();
    applyStimulus("reset_in_pend", 1, 0, 32'h0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0,
                  0, 0, 0, 1, 1, 1, 32'h0);
    checkOutput();
    idleStep("no_redirect_after_reset");
    idleStep("still_run_after_reset");
    checkCounters("reset_in_pend", 0, 0);

    applyStimulus("sat_stall", 0, 0, 32'h0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0,
                  1, 0, 0, 1, 0, 0, 32'h0);
    checkOutput();
    repeat ((1 << CNT_W) + 5) @(negedge clk);
    idleStep("after_sat");
    checkCounters("saturate", (1 << CNT_W) - 1, 0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
Control block that sequences the program counter and the front-end pipeline registers (IF/ID, ID/EX). It arbitrates three events that compete for the PC update: EX-stage taken-branch redirects, ID-stage load-use hazards, and instruction-memory wait states. It drives the PC's hold/select/target inputs and the stage hold/flush signals, and keeps performance counters.

Parameters:
CNT_W, 16, width of the saturating performance counters
XLEN, 32, address width of the PC and branch target

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
ex_branch_taken  in  1  EX stage resolved a taken branch/jump this cycle
ex_branch_target  in  XLEN  target of that branch
ex_mem_read  in  1  instruction in EX is a load
ex_rd  in  5  destination register of the EX instruction
id_rs1  in  5  source register 1 of the ID instruction
id_rs2  in  5  source register 2 of the ID instruction
id_uses_rs1  in  1  ID instruction reads rs1
id_uses_rs2  in  1  ID instruction reads rs2
imem_ready  in  1  instruction fetch completes this cycle
imem_req  out  1  fetch request to instruction memory
pc_hold  out  1  to PC pcwrite: 1 = PC keeps its value
pc_src  out  1  to PC pcSrc: 1 = load pc_target
pc_target  out  XLEN  to PC branchAddr
if_id_hold  out  1  IF/ID register keeps contents
if_id_flush  out  1  IF/ID register loads a bubble
id_ex_flush  out  1  ID/EX register loads a bubble
stall_cycles  out  CNT_W  saturating count of cycles with pc_hold=1
redirect_count  out  CNT_W  saturating count of accepted branch redirects

Behaviour:
- State register has two states: RUN and REDIR_PEND. There is also a registered redirect_addr (XLEN).
- Reset, when sampled: state=RUN, redirect_addr=0, both counters=0. While reset=1, outputs are imem_req=0, pc_hold=0, pc_src=0, pc_target=0, if_id_hold=0, if_id_flush=1, id_ex_flush=1. Reset mid-REDIR_PEND discards the pending redirect.
- Outputs are combinational from state and inputs. PC and pipeline registers sample them on the same posedge, so there are zero cycles of added latency.
- load_use = ex_mem_read & (ex_rd!=0) & ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd)).
- RUN priority is branch > load_use > imem wait.
  - Branch with imem_ready=1: pc_src=1, pc_target=ex_branch_target, pc_hold=0, if_id_flush=1, id_ex_flush=1. redirect_count increments. Stay in RUN.
  - Branch with imem_ready=0: pc_hold=1, pc_src=0, if_id_flush=1, id_ex_flush=1. Latch redirect_addr=ex_branch_target, go to REDIR_PEND. redirect_count increments.
  - load_use, no branch: pc_hold=1, if_id_hold=1, if_id_flush=0, id_ex_flush=1 for one cycle. This holds for either value of imem_ready; hold beats flush on IF/ID.
  - imem_ready=0 alone: pc_hold=1, if_id_flush=1 (bubble), id_ex_flush=0.
  - Otherwise: all control outputs 0, and the PC advances by 4.
- REDIR_PEND:
  - pc_target=redirect_addr.
  - imem_ready=0: pc_hold=1, if_id_flush=1, id_ex_flush=1. Stay.
  - imem_ready=1: pc_src=1, pc_hold=0, if_id_flush=1, id_ex_flush=1. Go to RUN.
  - ex_branch_taken here overwrites redirect_addr, and redirect_count increments. Load-use is ignored because ID is being flushed.
- imem_req=1 whenever reset=0.
- Counters saturate at all-ones and never wrap. stall_cycles increments on every non-reset cycle with pc_hold=1.
- Output invariants:
  - pc_src=1 implies pc_hold=0.
  - if_id_hold and if_id_flush are never both 1.

Decomposition:
- Shared package holds:
  - state encoding constants: RUN=1'b0, REDIR_PEND=1'b1;
  - PC_STEP=4;
  - register-index width 5.
- One sub-module is natural: sat_counter (parameter CNT_W; inputs clk, reset, inc; output count). It is instantiated twice.

Test Plan:
- Reset held 3 cycles, then released with imem_ready=1 and no hazards -> during reset flushes=1 and imem_req=0; after release pc_hold=0, pc_src=0, counters=0.
- ex_branch_taken=1, target=0x0000_0100, imem_ready=1 -> same cycle pc_src=1, pc_target=0x100, both flushes=1; redirect_count=1; state stays RUN.
- Branch to 0x200 with imem_ready=0 for 3 cycles, then 1 -> REDIR_PEND; pc_hold=1 for 3 cycles, then pc_src=1 with pc_target=0x200; stall_cycles=3.
- ex_mem_read=1, ex_rd=5, id_rs2=5, id_uses_rs2=1 -> one cycle of pc_hold=1, if_id_hold=1, id_ex_flush=1. The same case with ex_rd=0 -> no stall.
- Load-use and taken branch in the same cycle -> branch wins: if_id_hold=0, pc_src=1.
- Force 2^CNT_W+5 stall cycles -> stall_cycles stays at 0xFFFF. Reset asserted in REDIR_PEND -> after reset, no redirect is issued when imem_ready rises.
